// File: rtl/coreuart_tx_fifo_gen2.sv
// CoreUART transmitter with a built-in TX FIFO and run-time frame format (5-9 data bits, parity, 1/2 stop).
// Define CORE_UART_TX_BREAK_EN to enable break generation on the break_req input.
module coreuart_tx_fifo_gen2 #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 9,
    parameter int IDLE_GAP   = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        xmit_pulse,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_en,
    input  logic [2:0]                  char_len,
    input  logic                        parity_en,
    input  logic                        odd_n_even,
    input  logic                        two_stop,
    input  logic                        break_req,
    output logic                        tx,
    output logic                        txrdy,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    GAP_LAST = 4'(IDLE_GAP - 1);

`ifdef CORE_UART_TX_BREAK_EN
    typedef enum logic [3:0] {IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2, GAP, BREAK} state_t;
`else
    typedef enum logic [3:0] {IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2, GAP} state_t;
    logic unused_break;
    assign unused_break = break_req;
`endif

    localparam state_t AFTER_STOP = (IDLE_GAP > 0) ? GAP : IDLE;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;

    logic [DATA_W-1:0] head_q, shreg;
    logic [3:0]        len_d, len_q, bit_cnt, gap_cnt;
    logic              par_en_q, odd_q, two_q, par_acc, armed, last_data;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = LOAD;
`ifdef CORE_UART_TX_BREAK_EN
                if (break_req) state_d = BREAK;
`endif
            end
            LOAD:   if (armed && xmit_pulse) state_d = START;
            START:  if (xmit_pulse) state_d = DATA;
            DATA:   if (xmit_pulse && last_data) state_d = par_en_q ? PARITY : STOP1;
            PARITY: if (xmit_pulse) state_d = STOP1;
            STOP1:  if (xmit_pulse) state_d = two_q ? STOP2 : AFTER_STOP;
            STOP2:  if (xmit_pulse) state_d = AFTER_STOP;
            GAP:    if (xmit_pulse && gap_cnt == GAP_LAST) state_d = IDLE;
`ifdef CORE_UART_TX_BREAK_EN
            BREAK:  if (xmit_pulse && !break_req && bit_cnt == 4'd1) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs and control strobes
    always_comb begin
        full       = (count == FULL_CNT);
        empty      = (count == '0);
        push       = wr_en && !full;
        pop        = (state_q == IDLE) && (state_d == LOAD);
        last_data  = (bit_cnt == len_q - 4'd1);
        txrdy      = !full;
        fifo_empty = empty;
        fifo_count = count;
        tx_busy    = (state_q != IDLE);
        case (char_len)
            3'd0:    len_d = 4'd5;
            3'd1:    len_d = 4'd6;
            3'd2:    len_d = 4'd7;
            3'd4:    len_d = 4'd9;
            default: len_d = 4'd8;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The head is staged on the pop edge; LOAD's first clk moves it into the
    // shifter and latches the frame format, and only then accepts xmit_pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx       <= 1'b1;
            head_q   <= '0;
            shreg    <= '0;
            len_q    <= 4'd8;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            two_q    <= 1'b0;
            par_acc  <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            if (pop) head_q <= mem[rd_ptr];
            case (state_q)
                IDLE: begin
                    armed   <= 1'b0;
                    bit_cnt <= '0;
                end
                LOAD: begin
                    if (!armed) begin
                        shreg    <= head_q;
                        len_q    <= len_d;
                        par_en_q <= parity_en;
                        odd_q    <= odd_n_even;
                        two_q    <= two_stop;
                        par_acc  <= 1'b0;
                        bit_cnt  <= '0;
                        armed    <= 1'b1;
                    end else if (xmit_pulse) begin
                        tx <= 1'b0;
                    end
                end
                START, DATA: begin
                    if (xmit_pulse) begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[DATA_W-1:1]};
                        par_acc <= par_acc ^ shreg[0];
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PARITY: if (xmit_pulse) tx <= par_acc ^ odd_q;
                STOP1, STOP2: begin
                    if (xmit_pulse) begin
                        tx      <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (xmit_pulse) begin
                        tx      <= 1'b1;
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
`ifdef CORE_UART_TX_BREAK_EN
                BREAK: begin
                    if (xmit_pulse) begin
                        if (break_req) begin
                            tx      <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            tx      <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
